// File: rtl/ex_stage.sv
`timescale 1ns/1ps
// ex_stage: execute stage of the 5-stage pipeline.
// Holds the ID/EX pipeline register and the ALU. The ALU result is produced
// combinationally from the register so ID can forward it in the same cycle.
module ex_stage #(
  parameter int          WIDTH     = 32,
  parameter logic [3:0]  TYPE_NONE = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cu_wreg,
  input  logic             cu_m2reg,
  input  logic             cu_wmem,
  input  logic [5:0]       cu_aluc,
  input  logic             cu_shift,
  input  logic             cu_aluimm,
  input  logic [WIDTH-1:0] id_a_in,
  input  logic [WIDTH-1:0] id_b_in,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_destR,
  input  logic [3:0]       ID_ins_type,
  input  logic [3:0]       ID_ins_number,
  input  logic             ex_flush,
  output logic             ex_wreg,
  output logic             ex_m2reg,
  output logic             ex_wmem,
  output logic [4:0]       ex_destR,
  output logic [WIDTH-1:0] ex_aluR,
  output logic [WIDTH-1:0] ex_b,
  output logic             ex_ov,
  output logic [3:0]       EX_ins_type,
  output logic [3:0]       EX_ins_number
);

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_AND  = 6'b000010;
  localparam logic [5:0] ALU_OR   = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_NOR  = 6'b000101;
  localparam logic [5:0] ALU_SLT  = 6'b000110;
  localparam logic [5:0] ALU_SLTU = 6'b000111;
  localparam logic [5:0] ALU_SLL  = 6'b001000;
  localparam logic [5:0] ALU_SRL  = 6'b001001;
  localparam logic [5:0] ALU_SRA  = 6'b001010;
  localparam logic [5:0] ALU_LUI  = 6'b001011;

  // ID/EX pipeline register fields
  logic             wreg_r;
  logic             m2reg_r;
  logic             wmem_r;
  logic [4:0]       destr_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] imm_r;
  logic [5:0]       aluc_r;
  logic             shift_r;
  logic             aluimm_r;
  logic [3:0]       type_r;
  logic [3:0]       number_r;

  // ALU datapath
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [4:0]       shamt_s;
  logic [WIDTH-1:0] result_s;
  logic             ov_s;

  // ID/EX register: loads every cycle; a flush kills only the side-effecting enables and the type tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wreg_r   <= 1'b0;
      m2reg_r  <= 1'b0;
      wmem_r   <= 1'b0;
      destr_r  <= 5'd0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      imm_r    <= {WIDTH{1'b0}};
      aluc_r   <= 6'd0;
      shift_r  <= 1'b0;
      aluimm_r <= 1'b0;
      type_r   <= TYPE_NONE;
      number_r <= 4'd0;
    end else begin
      wreg_r   <= cu_wreg  & ~ex_flush;
      m2reg_r  <= cu_m2reg & ~ex_flush;
      wmem_r   <= cu_wmem  & ~ex_flush;
      type_r   <= ex_flush ? TYPE_NONE : ID_ins_type;
      destr_r  <= id_destR;
      a_r      <= id_a_in;
      b_r      <= id_b_in;
      imm_r    <= id_imm;
      aluc_r   <= cu_aluc;
      shift_r  <= cu_shift;
      aluimm_r <= cu_aluimm;
      number_r <= ID_ins_number;
    end
  end

  // ALU: operand selection, operation decode and signed overflow for ADD/SUB
  always_comb begin
    op_a_s   = {WIDTH{1'b0}};
    op_b_s   = {WIDTH{1'b0}};
    result_s = {WIDTH{1'b0}};
    ov_s     = 1'b0;
    if (shift_r) begin
      op_a_s = {{(WIDTH-5){1'b0}}, imm_r[10:6]};
    end else begin
      op_a_s = a_r;
    end
    if (aluimm_r) begin
      op_b_s = imm_r;
    end else begin
      op_b_s = b_r;
    end
    sum_s   = op_a_s + op_b_s;
    diff_s  = op_a_s - op_b_s;
    shamt_s = op_a_s[4:0];
    case (aluc_r)
      ALU_ADD: begin
        result_s = sum_s;
        ov_s     = (op_a_s[WIDTH-1] == op_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != op_a_s[WIDTH-1]);
      end
      ALU_SUB: begin
        result_s = diff_s;
        ov_s     = (op_a_s[WIDTH-1] != op_b_s[WIDTH-1]) && (diff_s[WIDTH-1] != op_a_s[WIDTH-1]);
      end
      ALU_AND:  result_s = op_a_s & op_b_s;
      ALU_OR:   result_s = op_a_s | op_b_s;
      ALU_XOR:  result_s = op_a_s ^ op_b_s;
      ALU_NOR:  result_s = ~(op_a_s | op_b_s);
      ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
      ALU_SLL:  result_s = op_b_s << shamt_s;
      ALU_SRL:  result_s = op_b_s >> shamt_s;
      ALU_SRA:  result_s = $unsigned($signed(op_b_s) >>> shamt_s);
      ALU_LUI:  result_s = {op_b_s[15:0], 16'h0000};
      default:  result_s = {WIDTH{1'b0}};
    endcase
  end

  assign ex_wreg       = wreg_r;
  assign ex_m2reg      = m2reg_r;
  assign ex_wmem       = wmem_r;
  assign ex_destR      = destr_r;
  assign ex_b          = b_r;
  assign EX_ins_type   = type_r;
  assign EX_ins_number = number_r;
  assign ex_aluR       = result_s;
  assign ex_ov         = ov_s;

endmodule
